// File: rtl/cascade_and_pkg.sv
// cascade_and_pkg: FSM state type, reset vector table ({d1,d0} = 00,01,01,11,01,10) and default sizes for cascade_and_pattern_gen
package cascade_and_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NUM_VEC_DEF = 6;
  localparam int IDX_W_DEF = 3;
  localparam int CNT_W_DEF = 8;
  localparam logic [5:0][1:0] RST_TBL = {2'b10, 2'b01, 2'b11, 2'b01, 2'b01, 2'b00};
  function automatic logic [1:0] rst_entry(input int i);
    return (i < 6) ? RST_TBL[i[2:0]] : 2'b00;
  endfunction
endpackage

// File: rtl/cascade_hold_timer.sv
// cascade_hold_timer: loadable down-counter (clk, rst_n, load, load_val in; expire out when count==0), stops at zero
module cascade_hold_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expire = (cnt_q == '0);
endmodule

// File: rtl/cascade_and_pattern_gen.sv
// cascade_and_pattern_gen: steps a writable {d1,d0} table (start/abort/hold_len/wr_* in; busy/done/vec_idx/d0/d1/exp_and out); CASCADE_PATGEN_LOOP_EN adds loop_en
module cascade_and_pattern_gen
  import cascade_and_pkg::*;
#(
  parameter int NUM_VEC = NUM_VEC_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] hold_len,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [1:0]       wr_data,
`ifdef CASCADE_PATGEN_LOOP_EN
  input  logic             loop_en,
`endif
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] vec_idx,
  output logic             d0,
  output logic             d1,
  output logic             exp_and
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
  state_t state_q, state_d;
  logic [1:0] tbl_q [NUM_VEC];
  logic [1:0] tbl_d [NUM_VEC];
  logic [IDX_W-1:0] vec_idx_q, vec_idx_d;
  logic [CNT_W-1:0] hold_q, hold_d, load_val;
  logic busy_q, done_q, d0_q, d1_q, d0_d, d1_d, exp_and_q;
  logic load, expire, loop;
`ifdef CASCADE_PATGEN_LOOP_EN
  assign loop = loop_en;
`else
  assign loop = 1'b0;
`endif
  cascade_hold_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );
  always_comb begin
    tbl_d = tbl_q;
    if (wr_en && !busy_q && wr_addr <= LAST_IDX) tbl_d[wr_addr] = wr_data;
    state_d = state_q;
    vec_idx_d = vec_idx_q;
    hold_d = hold_q;
    load = 1'b0;
    load_val = hold_q - CNT_W'(1);
    unique case (state_q)
      IDLE:
        if (start && !abort) begin
          state_d = RUN;
          vec_idx_d = '0;
          hold_d = (hold_len == '0) ? CNT_W'(1) : hold_len;
          load = 1'b1;
          load_val = hold_d - CNT_W'(1);
        end
      RUN:
        if (abort) begin
          state_d = IDLE;
          vec_idx_d = '0;
          load = 1'b1;
          load_val = '0;
        end else if (expire) begin
          if (vec_idx_q != LAST_IDX) begin
            vec_idx_d = vec_idx_q + IDX_W'(1);
            load = 1'b1;
          end else if (loop) begin
            vec_idx_d = '0;
            load = 1'b1;
          end else begin
            state_d = DONE;
            vec_idx_d = '0;
          end
        end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    {d1_d, d0_d} = (state_d == RUN) ? tbl_d[vec_idx_d] : 2'b00;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      vec_idx_q <= '0;
      hold_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      d0_q <= 1'b0;
      d1_q <= 1'b0;
      exp_and_q <= 1'b0;
      for (int i = 0; i < NUM_VEC; i++) tbl_q[i] <= rst_entry(i);
    end else begin
      state_q <= state_d;
      vec_idx_q <= vec_idx_d;
      hold_q <= hold_d;
      busy_q <= (state_d == RUN);
      done_q <= (state_d == DONE);
      d0_q <= d0_d;
      d1_q <= d1_d;
      exp_and_q <= d0_q & d1_q;
      tbl_q <= tbl_d;
    end
  assign busy = busy_q;
  assign done = done_q;
  assign vec_idx = vec_idx_q;
  assign d0 = d0_q;
  assign d1 = d1_q;
  assign exp_and = exp_and_q;
endmodule

// File: tb/tb_cascade_and_pattern_gen.sv
// tb_cascade_and_pattern_gen: directed table plus randomized runs checked against a cycle-indexed run model
module tb_cascade_and_pattern_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic wr_en = 1'b0;
  logic [7:0] hold_len = '0;
  logic [2:0] wr_addr = '0;
  logic [1:0] wr_data = '0;
  logic busy, done, d0, d1, exp_and;
  logic [2:0] vec_idx;
`ifdef CASCADE_PATGEN_LOOP_EN
  logic loop_en = 1'b0;
`endif
  cascade_and_pattern_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .hold_len (hold_len),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
`ifdef CASCADE_PATGEN_LOOP_EN
    .loop_en  (loop_en),
`endif
    .busy     (busy),
    .done     (done),
    .vec_idx  (vec_idx),
    .d0       (d0),
    .d1       (d1),
    .exp_and  (exp_and)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic       busy;
    logic       done;
    logic [2:0] idx;
    logic       d0;
    logic       d1;
    logic       ea;
  } row_t;
  row_t rows [14];
  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] tbl_m [6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input int c, input logic eb, input logic ed,
                         input logic [2:0] ei, input logic e0, input logic e1, input logic ea);
    chk($sformatf("%s.busy@%0d", tag, c), 32'(busy), 32'(eb));
    chk($sformatf("%s.done@%0d", tag, c), 32'(done), 32'(ed));
    chk($sformatf("%s.vec_idx@%0d", tag, c), 32'(vec_idx), 32'(ei));
    chk($sformatf("%s.d0@%0d", tag, c), 32'(d0), 32'(e0));
    chk($sformatf("%s.d1@%0d", tag, c), 32'(d1), 32'(e1));
    chk($sformatf("%s.exp_and@%0d", tag, c), 32'(exp_and), 32'(ea));
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_model();
    tbl_m = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b01, 2'b10};
  endtask
  task automatic idle_wr(input logic [2:0] a, input logic [1:0] v);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = v;
    step();
    wr_en = 1'b0;
    if (a < 3'd6) tbl_m[a] = v;
  endtask
  task automatic run_check(input string tag, input int h, input int ab, input bit wr0, input logic [1:0] wd0);
    int hv, len, last, ei;
    logic pa, eb, ed;
    logic [1:0] ev;
    hv = (h == 0) ? 1 : h;
    len = 6 * hv;
    last = (ab > 0) ? ab + 1 : len + 2;
    pa = 1'b0;
    hold_len = 8'(h);
    start = 1'b1;
    if (wr0) begin
      wr_en = 1'b1;
      wr_addr = 3'd0;
      wr_data = wd0;
      tbl_m[0] = wd0;
    end
    step();
    start = 1'b0;
    wr_en = 1'b0;
    for (int c = 1; c <= last; c++) begin
      eb = 1'b0;
      ed = 1'b0;
      ei = 0;
      ev = 2'b00;
      if (!(ab > 0 && c > ab)) begin
        if (c <= len) begin
          eb = 1'b1;
          ei = (c - 1) / hv;
          ev = tbl_m[ei];
        end else if (c == len + 1) ed = 1'b1;
      end
      chk_all(tag, c, eb, ed, 3'(ei), ev[0], ev[1], pa);
      pa = ev[0] & ev[1];
      if (eb) begin
        start = 1'($urandom);
        hold_len = 8'($urandom);
        wr_en = 1'($urandom);
        wr_addr = 3'($urandom);
        wr_data = 2'($urandom);
        abort = (c == ab);
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
        abort = 1'b0;
      end
      step();
    end
    start = 1'b0;
    wr_en = 1'b0;
    abort = 1'b0;
  endtask
  initial begin
    rows[0]  = 8'b10_000_000;
    rows[1]  = 8'b10_000_000;
    rows[2]  = 8'b10_001_100;
    rows[3]  = 8'b10_001_100;
    rows[4]  = 8'b10_010_100;
    rows[5]  = 8'b10_010_100;
    rows[6]  = 8'b10_011_110;
    rows[7]  = 8'b10_011_111;
    rows[8]  = 8'b10_100_101;
    rows[9]  = 8'b10_100_100;
    rows[10] = 8'b10_101_010;
    rows[11] = 8'b10_101_010;
    rows[12] = 8'b01_000_000;
    rows[13] = 8'b00_000_000;
    reset_model();
    #1 rst_n = 1'b0;
    #1 chk_all("reset_async", 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_all("reset_idle", 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    hold_len = 8'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      chk_all("table_h2", i + 1, rows[i].busy, rows[i].done, rows[i].idx, rows[i].d0, rows[i].d1, rows[i].ea);
      step();
    end
    run_check("hold0", 0, 0, 1'b0, 2'b00);
    idle_wr(3'd3, 2'b00);
    idle_wr(3'd6, 2'b11);
    idle_wr(3'd7, 2'b11);
    run_check("wr3_h1", 1, 0, 1'b0, 2'b00);
    run_check("abort_h3", 3, 4, 1'b0, 2'b00);
    run_check("after_abort", 2, 0, 1'b0, 2'b00);
    run_check("wr_start", 1, 0, 1'b1, 2'b11);
    run_check("hold255", 255, 0, 1'b0, 2'b00);
    for (int r = 0; r < 20; r++) begin
      int h, ab;
      repeat ($urandom_range(0, 2)) idle_wr(3'($urandom), 2'($urandom));
      h = $urandom_range(0, 5);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6 * ((h == 0) ? 1 : h)) : 0;
      run_check($sformatf("rand%0d", r), h, ab, 1'($urandom), 2'($urandom));
    end
    idle_wr(3'd3, 2'b00);
    hold_len = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1 chk_all("midrun_rst", 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("midrun_rst_hold", 1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    reset_model();
    step();
    run_check("post_rst", 1, 0, 1'b0, 2'b00);
`ifdef CASCADE_PATGEN_LOOP_EN
    loop_en = 1'b1;
    hold_len = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      chk($sformatf("loop.vec_idx@%0d", c), 32'(vec_idx), 32'((c - 1) % 6));
      chk($sformatf("loop.done@%0d", c), 32'(done), 32'(0));
      step();
    end
    loop_en = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("loop.abort_busy", 32'(busy), 32'(0));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
